// File: rtl/pmem_line_adapter_pkg.sv
// pmem_line_adapter_pkg
// Shared types and helpers for the pmem line adapter.
//   - state_e      : adapter FSM states (IDLE, RD_BURST, WR_BURST, RESP)
//   - DEF_*        : default geometry (256-bit line, 64-bit beats, 32-bit address)
//   - BEATS, CNT_W, OFFSET_W : geometry derived from the defaults
//   - beat_cnt_width()       : counter width for a given beat count (min 1 bit)
//   - line_align()           : clears the byte-offset bits of an address
package pmem_line_adapter_pkg;

   localparam int DEF_LINE_W  = 256;
   localparam int DEF_BURST_W = 64;
   localparam int DEF_ADDR_W  = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      RESP     = 2'd3
   } state_e;

   // A one-beat line still needs a 1-bit counter so port widths stay legal.
   function automatic int beat_cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   // Works on a 64-bit container so any address width up to 64 can use it;
   // callers truncate the result back to their own width.
   function automatic logic [63:0] line_align(input logic [63:0] addr,
                                              input int unsigned offset_w);
      return addr & ~((64'd1 << offset_w) - 64'd1);
   endfunction

   localparam int BEATS    = DEF_LINE_W / DEF_BURST_W;
   localparam int CNT_W    = beat_cnt_width(BEATS);
   localparam int OFFSET_W = $clog2(DEF_LINE_W / 8);

endpackage

// File: rtl/pmem_line_adapter_beat_counter.sv
// beat_counter
// Counts accepted beats of a memory burst and flags the final one.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : synchronous clear (adapter idle)
//   enable    : one beat accepted this cycle
//   cnt       : index of the beat currently on the bus
//   last      : cnt is the final beat index
module beat_counter #(
   parameter int BEATS = 4,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign last = (cnt_q == CNT_W'(BEATS - 1));
   assign cnt  = cnt_q;

   // Wrap explicitly on the final beat so non-power-of-two beat counts
   // also return to slot 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pmem_line_adapter.sv
// pmem_line_adapter
// Turns whole-line cache requests (pmem_read / pmem_write, held until
// pmem_resp) into BEATS-long bursts on the memory-side bus and answers each
// with a one-cycle pmem_resp.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   pmem_address/read/write    : line request from the cache side
//   pmem_wdata / pmem_rdata    : full line in / assembled line out
//   pmem_resp                  : one-cycle completion pulse
//   mem_address/read/write     : line-aligned burst request to memory
//   mem_wdata / mem_rdata      : current beat out / in
//   mem_resp                   : qualifies one beat per cycle
//   perf_reads / perf_writes   : completed line reads / writes
// Build option: define PMEM_LINE_ADAPTER_PERF_EN to get live 32-bit
// wrap-around completion counters; otherwise both outputs are tied to 0.
module pmem_line_adapter
   import pmem_line_adapter_pkg::*;
#(
   parameter int LINE_W  = DEF_LINE_W,
   parameter int BURST_W = DEF_BURST_W,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pmem_address,
   input  logic               pmem_read,
   input  logic               pmem_write,
   input  logic [LINE_W-1:0]  pmem_wdata,
   output logic [LINE_W-1:0]  pmem_rdata,
   output logic               pmem_resp,
   output logic [ADDR_W-1:0]  mem_address,
   output logic               mem_read,
   output logic               mem_write,
   output logic [BURST_W-1:0] mem_wdata,
   input  logic [BURST_W-1:0] mem_rdata,
   input  logic               mem_resp,
   output logic [31:0]        perf_reads,
   output logic [31:0]        perf_writes
);

   localparam int NUM_BEATS     = LINE_W / BURST_W;
   localparam int BEAT_CNT_W    = beat_cnt_width(NUM_BEATS);
   localparam int LINE_OFFSET_W = $clog2(LINE_W / 8);

   state_e state_q;
   state_e state_d;

   logic [ADDR_W-1:0]     addr_q;
   logic [ADDR_W-1:0]     addr_d;
   logic [LINE_W-1:0]     wline_q;
   logic [LINE_W-1:0]     wline_d;
   logic [LINE_W-1:0]     rline_q;
   logic [LINE_W-1:0]     rline_d;
   logic [ADDR_W-1:0]     addr_aligned;
   logic [BEAT_CNT_W-1:0] cnt;
   logic                  last;
   logic                  beat_en;
   logic                  cnt_clear;

   assign addr_aligned = ADDR_W'(line_align(64'(pmem_address), LINE_OFFSET_W));
   assign cnt_clear    = (state_q == IDLE);

   beat_counter #(
      .BEATS (NUM_BEATS),
      .CNT_W (BEAT_CNT_W)
   ) u_beat_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (beat_en),
      .cnt    (cnt),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Write has priority when both requests are up; requests are only
   // looked at in IDLE, so a request still high during RESP is not re-taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (pmem_write) begin
               state_d = WR_BURST;
            end else if (pmem_read) begin
               state_d = RD_BURST;
            end
         end
         RD_BURST, WR_BURST: begin
            if (mem_resp && last) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mem_wdata is zeroed outside a write burst so the bus is quiet when idle.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      pmem_resp = 1'b0;
      mem_wdata = '0;
      beat_en   = 1'b0;
      unique case (state_q)
         RD_BURST: begin
            mem_read = 1'b1;
            beat_en  = mem_resp;
         end
         WR_BURST: begin
            mem_write = 1'b1;
            mem_wdata = wline_q[cnt*BURST_W +: BURST_W];
            beat_en   = mem_resp;
         end
         RESP:    pmem_resp = 1'b1;
         default: ;
      endcase
   end

   // Address and write line are captured once at acceptance so they stay
   // constant for the burst; read beats land in their slot as they arrive.
   always_comb begin
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      if (state_q == IDLE) begin
         if (pmem_write) begin
            addr_d  = addr_aligned;
            wline_d = pmem_wdata;
         end else if (pmem_read) begin
            addr_d = addr_aligned;
         end
      end
      if ((state_q == RD_BURST) && mem_resp) begin
         rline_d[cnt*BURST_W +: BURST_W] = mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
      end
   end

   assign mem_address = addr_q;
   assign pmem_rdata  = rline_q;

`ifdef PMEM_LINE_ADAPTER_PERF_EN
   logic        op_write_q;
   logic        op_write_d;
   logic [31:0] perf_reads_q;
   logic [31:0] perf_reads_d;
   logic [31:0] perf_writes_q;
   logic [31:0] perf_writes_d;

   // Remember which kind of request was accepted so RESP can bump the
   // matching counter.
   always_comb begin
      op_write_d    = op_write_q;
      perf_reads_d  = perf_reads_q;
      perf_writes_d = perf_writes_q;
      if (state_q == IDLE) begin
         op_write_d = pmem_write;
      end
      if (state_q == RESP) begin
         if (op_write_q) begin
            perf_writes_d = perf_writes_q + 32'd1;
         end else begin
            perf_reads_d = perf_reads_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_write_q    <= 1'b0;
         perf_reads_q  <= '0;
         perf_writes_q <= '0;
      end else begin
         op_write_q    <= op_write_d;
         perf_reads_q  <= perf_reads_d;
         perf_writes_q <= perf_writes_d;
      end
   end

   assign perf_reads  = perf_reads_q;
   assign perf_writes = perf_writes_q;
`else
   assign perf_reads  = '0;
   assign perf_writes = '0;
`endif

endmodule

// File: tb/tb_pmem_line_adapter.sv
// tb_pmem_line_adapter
// Self-checking bench for pmem_line_adapter. The driver plays both the cache
// requester and the burst memory; a transaction-level model (current line
// address, last completed read line, completion counts) yields the expected
// outputs for every cycle, checked by one compare process on the falling edge.
module tb_pmem_line_adapter;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int ADDR_W  = 32;
   localparam int BEATS   = LINE_W / BURST_W;

`ifdef PMEM_LINE_ADAPTER_PERF_EN
   localparam int PERF_ON = 1;
`else
   localparam int PERF_ON = 0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [ADDR_W-1:0]  pmem_address;
   logic               pmem_read;
   logic               pmem_write;
   logic [LINE_W-1:0]  pmem_wdata;
   logic [LINE_W-1:0]  pmem_rdata;
   logic               pmem_resp;
   logic [ADDR_W-1:0]  mem_address;
   logic               mem_read;
   logic               mem_write;
   logic [BURST_W-1:0] mem_wdata;
   logic [BURST_W-1:0] mem_rdata;
   logic               mem_resp;
   logic [31:0]        perf_reads;
   logic [31:0]        perf_writes;

   always #5 clk = ~clk;

   pmem_line_adapter dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_address (pmem_address),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .mem_address  (mem_address),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .perf_reads   (perf_reads),
      .perf_writes  (perf_writes)
   );

   int n_compared = 0;
   int n_mismatch = 0;

   // Transaction-level model state
   logic [31:0]  cur_addr   = '0;
   logic [255:0] last_rline = '0;
   logic [31:0]  perf_r_cnt = '0;
   logic [31:0]  perf_w_cnt = '0;

   // Expected outputs for the current cycle
   bit           exp_check = 0;
   logic         exp_mem_read;
   logic         exp_mem_write;
   logic         exp_pmem_resp;
   logic [31:0]  exp_mem_address;
   logic [63:0]  exp_mem_wdata;
   bit           exp_rdata_chk;
   logic [255:0] exp_rdata;
   logic [31:0]  exp_perf_r;
   logic [31:0]  exp_perf_w;

   task automatic checkOutput(input string name, input logic [255:0] act,
                              input logic [255:0] expv);
      n_compared++;
      if (act !== expv) begin
         n_mismatch++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // Single compare process, away from the rising edge
   always @(negedge clk) begin
      if (exp_check) begin
         checkOutput("mem_read",    256'(mem_read),    256'(exp_mem_read));
         checkOutput("mem_write",   256'(mem_write),   256'(exp_mem_write));
         checkOutput("pmem_resp",   256'(pmem_resp),   256'(exp_pmem_resp));
         checkOutput("mem_address", 256'(mem_address), 256'(exp_mem_address));
         checkOutput("mem_wdata",   256'(mem_wdata),   256'(exp_mem_wdata));
         checkOutput("perf_reads",  256'(perf_reads),  256'(exp_perf_r));
         checkOutput("perf_writes", 256'(perf_writes), 256'(exp_perf_w));
         if (exp_rdata_chk) begin
            checkOutput("pmem_rdata", pmem_rdata, exp_rdata);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [255:0] wd, input logic resp,
                                input logic [63:0] rdata);
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = addr;
      pmem_wdata   = wd;
      mem_resp     = resp;
      mem_rdata    = rdata;
   endtask

   task automatic setExpect(input logic mr, input logic mw, input logic pr,
                            input logic [63:0] wd, input bit rchk,
                            input logic [255:0] rd);
      exp_mem_read    = mr;
      exp_mem_write   = mw;
      exp_pmem_resp   = pr;
      exp_mem_wdata   = wd;
      exp_rdata_chk   = rchk;
      exp_rdata       = rd;
      exp_mem_address = cur_addr;
      exp_perf_r      = (PERF_ON != 0) ? perf_r_cnt : 32'd0;
      exp_perf_w      = (PERF_ON != 0) ? perf_w_cnt : 32'd0;
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [255:0] randLine();
      return {rand64(), rand64(), rand64(), rand64()};
   endfunction

   task automatic modelReset();
      cur_addr   = '0;
      last_rline = '0;
      perf_r_cnt = '0;
      perf_w_cnt = '0;
   endtask

   // Call from an idle cycle: one cycle with rst high, then a checked
   // all-zero cycle after it.
   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, $urandom, randLine(), 1'($urandom), rand64());
      setExpect(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, last_rline);
      stepCycle();
      rst = 1'b0;
      modelReset();
      applyStimulus(1'b0, 1'b0, $urandom, randLine(), 1'($urandom), rand64());
      setExpect(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, last_rline);
      stepCycle();
   endtask

   // One line transaction. gap_at/gap_len insert mem_resp-low cycles once
   // gap_at beats are done; rand_gaps randomizes them instead; abort_at >= 0
   // asserts rst once that many beats are done (resp_cycle then -1).
   task automatic runTxn(input bit is_write, input bit also_read, input logic [31:0] addr,
                         input logic [255:0] line, input int gap_at, input int gap_len,
                         input bit rand_gaps, input int abort_at, output int resp_cycle);
      int beats = 0;
      int gaps  = 0;
      int lows  = 0;
      int cyc   = 0;
      logic rd_req;
      logic r;
      logic [63:0] slice;
      rd_req = (!is_write) || also_read;
      resp_cycle = -1;

      applyStimulus(rd_req, is_write, addr, line, 1'($urandom), rand64());
      setExpect(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, last_rline);
      stepCycle();
      cyc = 1;
      cur_addr = addr & ~32'h1F;

      while (beats < BEATS) begin
         slice = line[beats*BURST_W +: BURST_W];
         if (abort_at >= 0 && beats == abort_at) begin
            rst = 1'b1;
            applyStimulus(rd_req, is_write, addr, line, 1'b0, rand64());
            setExpect(!is_write, is_write, 1'b0, is_write ? slice : 64'd0,
                      is_write, last_rline);
            stepCycle();
            rst = 1'b0;
            modelReset();
            applyStimulus(1'b0, 1'b0, addr, line, 1'b0, rand64());
            setExpect(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, last_rline);
            stepCycle();
            return;
         end
         r = 1'b1;
         if (rand_gaps) begin
            r = ($urandom_range(0, 3) != 0) || (lows >= 3);
         end else if (beats == gap_at && gaps < gap_len) begin
            r = 1'b0;
            gaps++;
         end
         lows = r ? 0 : lows + 1;
         applyStimulus(rd_req, is_write, addr, line, r,
                       (r && !is_write) ? slice : rand64());
         setExpect(!is_write, is_write, 1'b0, is_write ? slice : 64'd0,
                   is_write, last_rline);
         stepCycle();
         cyc++;
         if (r) beats++;
      end

      if (!is_write) last_rline = line;
      applyStimulus(rd_req, is_write, addr, line, 1'($urandom), rand64());
      setExpect(1'b0, 1'b0, 1'b1, 64'd0, 1'b1, last_rline);
      resp_cycle = cyc;
      stepCycle();
      if (is_write) perf_w_cnt = perf_w_cnt + 32'd1;
      else          perf_r_cnt = perf_r_cnt + 32'd1;

      applyStimulus(1'b0, 1'b0, $urandom, randLine(), 1'($urandom), rand64());
      setExpect(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, last_rline);
      stepCycle();
   endtask

   initial begin
      int rc;
      logic [255:0] l1;
      logic [255:0] lw;
      l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      lw = {64'hDEAD_3333_3333_BEEF, 64'hDEAD_2222_2222_BEEF,
            64'hDEAD_1111_1111_BEEF, 64'hDEAD_0000_0000_BEEF};

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
      modelReset();
      @(posedge clk);
      #1;
      setExpect(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 256'd0);
      exp_check = 1;
      stepCycle();
      rst = 1'b0;
      checkOutput("rst_pmem_rdata", pmem_rdata, 256'd0);
      checkOutput("rst_mem_address", 256'(mem_address), 256'd0);
      stepCycle();

      $display("[TB] plain read of 0x1234");
      runTxn(1'b0, 1'b0, 32'h0000_1234, l1, -1, 0, 1'b0, -1, rc);
      checkOutput("lit_read_latency", 256'(rc), 256'd5);
      checkOutput("lit_read_addr", 256'(mem_address), 256'h0000_1220);
      checkOutput("lit_read_line", pmem_rdata,
                  256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

      $display("[TB] read with a 3-cycle beat gap");
      runTxn(1'b0, 1'b0, 32'h0000_1234, l1, 1, 3, 1'b0, -1, rc);
      checkOutput("lit_gap_latency", 256'(rc), 256'd8);
      checkOutput("lit_gap_line", pmem_rdata,
                  256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

      $display("[TB] line write to 0x40");
      runTxn(1'b1, 1'b0, 32'h0000_0040, lw, 2, 2, 1'b0, -1, rc);
      checkOutput("lit_write_addr", 256'(mem_address), 256'h40);
      checkOutput("lit_write_low", 256'(mem_write), 256'd0);

      $display("[TB] read and write together");
      doReset();
      runTxn(1'b1, 1'b1, 32'h0000_0300, randLine(), -1, 0, 1'b0, -1, rc);
      checkOutput("lit_both_perf_w", 256'(perf_writes), 256'(PERF_ON ? 1 : 0));
      checkOutput("lit_both_perf_r", 256'(perf_reads), 256'd0);

      $display("[TB] reset after beat 2 of a read");
      runTxn(1'b0, 1'b0, 32'h0000_0080, randLine(), -1, 0, 1'b0, 2, rc);
      checkOutput("lit_abort_resp", 256'(pmem_resp), 256'd0);
      runTxn(1'b0, 1'b0, 32'h0000_0080, l1, -1, 0, 1'b0, -1, rc);
      checkOutput("lit_after_abort_line", pmem_rdata,
                  256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

      $display("[TB] back-to-back reads");
      doReset();
      runTxn(1'b0, 1'b0, 32'h0000_0100, randLine(), -1, 0, 1'b0, -1, rc);
      runTxn(1'b0, 1'b0, 32'h0000_0200, randLine(), -1, 0, 1'b0, -1, rc);
      checkOutput("lit_b2b_perf_r", 256'(perf_reads), 256'(PERF_ON ? 2 : 0));
      checkOutput("lit_b2b_addr", 256'(mem_address), 256'h200);

      $display("[TB] randomized transactions");
      for (int i = 0; i < 40; i++) begin
         int op;
         op = $urandom_range(0, 2);
         runTxn(op != 0, op == 2, $urandom, randLine(), -1, 0, 1'b1, -1, rc);
      end

      exp_check = 0;
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
